// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and single-outstanding instruction fetcher feeding the IF/ID register.
module if_fetch_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_plus4_out
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DROP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_skid_pc;
  logic [WIDTH-1:0] r_skid_instr;
  logic             w_consume;
  logic             w_take;
  assign w_consume = fetch_valid && !stall;
  assign w_take    = !fetch_valid || w_consume;
  assign imem_req  = r_state == ISSUE;
  assign imem_addr = r_pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      fetch_valid  <= 1'b0;
      pc_out       <= '0;
      instr_out    <= '0;
      pc_plus4_out <= '0;
    end else if (redirect_valid) begin
      r_pc         <= redirect_pc;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      fetch_valid  <= 1'b0;
      pc_out       <= '0;
      instr_out    <= '0;
      pc_plus4_out <= '0;
      // A request still in flight must be drained before refetching; a response landing now drains it.
      r_state <= (r_state == ISSUE) ? DROP :
                 ((r_state == WAIT || r_state == DROP) && !imem_rvalid) ? DROP : ISSUE;
    end else begin
      if (w_consume) begin
        fetch_valid  <= 1'b0;
        pc_out       <= '0;
        instr_out    <= '0;
        pc_plus4_out <= '0;
      end
      case (r_state)
        IDLE:  r_state <= ISSUE;
        ISSUE: r_state <= WAIT;
        WAIT: if (imem_rvalid) begin
          r_pc <= r_pc + WIDTH'(4);
          if (w_take) begin
            fetch_valid  <= 1'b1;
            pc_out       <= r_pc;
            instr_out    <= imem_rdata;
            pc_plus4_out <= r_pc + WIDTH'(4);
            r_state      <= ISSUE;
          end else begin
            r_skid_pc    <= r_pc;
            r_skid_instr <= imem_rdata;
            r_state      <= HOLD;
          end
        end
        HOLD: if (w_consume) begin
          fetch_valid  <= 1'b1;
          pc_out       <= r_skid_pc;
          instr_out    <= r_skid_instr;
          pc_plus4_out <= r_skid_pc + WIDTH'(4);
          r_skid_pc    <= '0;
          r_skid_instr <= '0;
          r_state      <= ISSUE;
        end
        DROP: if (imem_rvalid) r_state <= ISSUE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch, stall/skid, redirect, wrap and async-reset checks.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        req0, fv0, req1, fv1;
  logic [31:0] addr0, pc0, ins0, p40, addr1, pc1, ins1, p41;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(req0), .imem_addr(addr0),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fetch_valid(fv0),
    .pc_out(pc0), .instr_out(ins0), .pc_plus4_out(p40));

  if_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(req1), .imem_addr(addr1),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fetch_valid(fv1),
    .pc_out(pc1), .instr_out(ins1), .pc_plus4_out(p41));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    chk("rst_fv", {31'b0, fv0}, 0);
    chk("rst_req", {31'b0, req0}, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_addr1", addr1, 32'hFFFF_FFFC);
    rst = 1'b0;
    tick();
    chk("e1_req", {31'b0, req0}, 1);
    chk("e1_addr", addr0, 0);
    tick();
    chk("e2_req", {31'b0, req0}, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    chk("e3_fv", {31'b0, fv0}, 1);
    chk("e3_pc", pc0, 0);
    chk("e3_instr", ins0, 32'h0000_0013);
    chk("e3_pc4", p40, 4);
    chk("e3_req", {31'b0, req0}, 1);
    chk("e3_addr", addr0, 4);
    chk("wrap_pc", pc1, 32'hFFFF_FFFC);
    chk("wrap_pc4", p41, 0);
    chk("wrap_addr", addr1, 0);
    imem_rvalid = 1'b0;
    tick();
    chk("e4_empty_fv", {31'b0, fv0}, 0);
    chk("e4_empty_pc4", p40, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0040_0093;
    tick();
    chk("e5_pc", pc0, 4);
    chk("e5_instr", ins0, 32'h0040_0093);
    chk("e5_addr", addr0, 8);
    stall = 1'b1; imem_rvalid = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0080_0113;
    tick();
    imem_rvalid = 1'b0;
    chk("hold_fv", {31'b0, fv0}, 1);
    chk("hold_pc", pc0, 4);
    chk("hold_req", {31'b0, req0}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc_loop", pc0, 4);
      chk("hold_req_loop", {31'b0, req0}, 0);
    end
    stall = 1'b0;
    tick();
    chk("skid_pc", pc0, 8);
    chk("skid_instr", ins0, 32'h0080_0113);
    chk("skid_pc4", p40, 12);
    chk("skid_req", {31'b0, req0}, 1);
    chk("skid_addr", addr0, 12);
    stall = 1'b1;
    tick();
    chk("pre_redir_fv", {31'b0, fv0}, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    chk("redir_fv", {31'b0, fv0}, 0);
    chk("redir_pc", pc0, 0);
    chk("redir_req", {31'b0, req0}, 0);
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    chk("drop_req", {31'b0, req0}, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("drop_fv", {31'b0, fv0}, 0);
    chk("drop_req2", {31'b0, req0}, 1);
    chk("drop_addr", addr0, 32'h0000_0100);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    chk("tgt_pc", pc0, 32'h0000_0100);
    chk("tgt_pc4", p40, 32'h0000_0104);
    chk("tgt_addr", addr0, 32'h0000_0104);
    stall = 1'b1; imem_rvalid = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    chk("coinc_fv", {31'b0, fv0}, 0);
    chk("coinc_instr", ins0, 0);
    chk("coinc_req", {31'b0, req0}, 1);
    chk("coinc_addr", addr0, 32'h0000_0200);
    redirect_valid = 1'b0; imem_rvalid = 1'b0; stall = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    chk("after_coinc_pc", pc0, 32'h0000_0200);
    chk("after_coinc_instr", ins0, 32'h3333_3333);
    stall = 1'b1; imem_rvalid = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0044;
    tick();
    imem_rvalid = 1'b0;
    chk("hold2_fv", {31'b0, fv0}, 1);
    chk("hold2_req", {31'b0, req0}, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_fv", {31'b0, fv0}, 0);
    chk("arst_pc", pc0, 0);
    chk("arst_instr", ins0, 0);
    chk("arst_pc4", p40, 0);
    chk("arst_req", {31'b0, req0}, 0);
    chk("arst_addr", addr0, 0);
    tick();
    rst = 1'b0; stall = 1'b0;
    tick();
    chk("restart_req", {31'b0, req0}, 1);
    chk("restart_addr", addr0, 0);
    chk("restart_addr1", addr1, 32'hFFFF_FFFC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
